// File: rtl/odd_parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), one parity
// bit and one stop bit. The captured data/parity pair is handed downstream
// with a one-cycle frame_valid strobe. A low stop bit gives a one-cycle
// frame_err strobe instead. Parity is deliberately not evaluated here.
module odd_parity_frame_rx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              parity_out,
   output logic              frame_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t state_q, state_d;

   logic              sync1_q;
   logic              rxS_q;
   logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
   logic [IDX_W-1:0]  bitIdx_q, bitIdx_d;
   logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
   logic              parityBit_q, parityBit_d;
   logic [DATA_W-1:0] dataOut_q, dataOut_d;
   logic              parityOut_q, parityOut_d;
   logic              frameValid_q, frameValid_d;
   logic              frameErr_q, frameErr_d;
   logic              sampleNow;

   // Two-flop synchroniser; the line idles high so reset loads ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rxS_q   <= 1'b1;
      end else begin
         sync1_q <= rx_in;
         rxS_q   <= sync1_q;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the start bit is sampled mid-bit, later bits one full bit period apart.
   always_comb begin
      state_d   = state_q;
      sampleNow = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxS_q) state_d = START;
         end
         START: begin
            sampleNow = (bitCnt_q == HALF_LAST);
            if (sampleNow) state_d = rxS_q ? IDLE : DATA;
         end
         DATA: begin
            sampleNow = (bitCnt_q == FULL_LAST);
            if (sampleNow && (bitIdx_q == IDX_LAST)) state_d = PARITY;
         end
         PARITY: begin
            sampleNow = (bitCnt_q == FULL_LAST);
            if (sampleNow) state_d = STOP;
         end
         STOP: begin
            sampleNow = (bitCnt_q == FULL_LAST);
            if (sampleNow) state_d = rxS_q ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (rxS_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output next values: counters, shift register, strobes and the held frame.
   always_comb begin
      bitCnt_d     = bitCnt_q + CNT_W'(1);
      bitIdx_d     = bitIdx_q;
      shiftReg_d   = shiftReg_q;
      parityBit_d  = parityBit_q;
      frameValid_d = 1'b0;
      frameErr_d   = 1'b0;
      if ((state_d != state_q) || sampleNow) begin
         bitCnt_d = '0;
      end
      if ((state_q == START) && (state_d == DATA)) begin
         bitIdx_d = '0;
      end
      if ((state_q == DATA) && sampleNow) begin
         shiftReg_d[bitIdx_q] = rxS_q;
         bitIdx_d             = bitIdx_q + IDX_W'(1);
      end
      if ((state_q == PARITY) && sampleNow) begin
         parityBit_d = rxS_q;
      end
      if ((state_q == STOP) && sampleNow) begin
         frameValid_d = rxS_q;
         frameErr_d   = !rxS_q;
      end
      dataOut_d   = frameValid_d ? shiftReg_q : dataOut_q;
      parityOut_d = frameValid_d ? parityBit_q : parityOut_q;
   end

   // Datapath and registered output storage; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         bitCnt_q     <= '0;
         bitIdx_q     <= '0;
         shiftReg_q   <= '0;
         parityBit_q  <= 1'b0;
         dataOut_q    <= '0;
         parityOut_q  <= 1'b0;
         frameValid_q <= 1'b0;
         frameErr_q   <= 1'b0;
      end else begin
         bitCnt_q     <= bitCnt_d;
         bitIdx_q     <= bitIdx_d;
         shiftReg_q   <= shiftReg_d;
         parityBit_q  <= parityBit_d;
         dataOut_q    <= dataOut_d;
         parityOut_q  <= parityOut_d;
         frameValid_q <= frameValid_d;
         frameErr_q   <= frameErr_d;
      end
   end

   assign data_out    = dataOut_q;
   assign parity_out  = parityOut_q;
   assign frame_valid = frameValid_q;
   assign frame_err   = frameErr_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_odd_parity_frame_rx.sv
// Testbench for odd_parity_frame_rx: directed scenarios plus random frames,
// with a scoreboard of expected strobes checked by an independent monitor.
module tb_odd_parity_frame_rx;

   localparam int DATA_W = 4;
   localparam int CPB    = 4;
   localparam int H      = CPB / 2;
   localparam int S_EDGE = 2 + H + (DATA_W + 2) * CPB;

   typedef struct {
      bit                isErr;
      logic [DATA_W-1:0] data;
      logic              par;
      int                cyc;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              rx_in;
   logic [DATA_W-1:0] data_out;
   logic              parity_out;
   logic              frame_valid;
   logic              frame_err;
   logic              busy;

   int                checks = 0;
   int                errors = 0;
   int                cycle  = 0;
   exp_t              expQ[$];
   logic [DATA_W-1:0] lastGoodData = '0;
   logic              lastGoodPar  = 1'b0;

   odd_parity_frame_rx #(
      .DATA_W(DATA_W),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_in(rx_in),
      .data_out(data_out),
      .parity_out(parity_out),
      .frame_valid(frame_valid),
      .frame_err(frame_err),
      .busy(busy)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to timestamp expected strobes.
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Drive a level for n clock edges; always leaves us 1 time unit after a posedge.
   task automatic holdBit(input logic v, input int n);
      rx_in = v;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Send one frame and record the strobe the reference model expects for it.
   task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic p, input logic stopBit);
      exp_t e;
      if (stopBit) begin
         lastGoodData = d;
         lastGoodPar  = p;
      end
      e.isErr = !stopBit;
      e.data  = lastGoodData;
      e.par   = lastGoodPar;
      e.cyc   = cycle + 1 + S_EDGE;
      expQ.push_back(e);
      holdBit(1'b0, CPB);
      for (int i = 0; i < DATA_W; i++) holdBit(d[i], CPB);
      holdBit(p, CPB);
      holdBit(stopBit, CPB);
   endtask

   // Monitor: pops the scoreboard whenever a strobe appears, flags strobes that never came.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid && frame_err) begin
            checks++;
            errors++;
            $display("[TB] FAIL bothStrobes: frame_valid and frame_err high together (cycle %0d)", cycle);
         end
         if (frame_valid || frame_err) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL spuriousPulse: valid=%0b err=%0b with nothing expected (cycle %0d)",
                        frame_valid, frame_err, cycle);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("strobeKindErr", 32'(frame_err), 32'(e.isErr));
               checkOutput("strobeCycle", 32'(cycle), 32'(e.cyc));
               checkOutput("dataOut", 32'(data_out), 32'(e.data));
               checkOutput("parityOut", 32'(parity_out), 32'(e.par));
            end
         end else if (expQ.size() > 0 && cycle > expQ[0].cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missingPulse: no strobe seen, expected at cycle %0d (now %0d)",
                     expQ[0].cyc, cycle);
            void'(expQ.pop_front());
         end
      end
   end

   // Directed scenarios followed by randomized frames, then drain and summary.
   initial begin
      logic [DATA_W-1:0] rd;
      logic              rp;
      logic              rs;

      rst   = 1'b1;
      rx_in = 1'b0;
      @(posedge clk);
      #1 rx_in = 1'b1;
      @(posedge clk);
      #1 rx_in = 1'b0;
      checkOutput("resetData", 32'(data_out), 32'(0));
      checkOutput("resetParity", 32'(parity_out), 32'(0));
      checkOutput("resetValid", 32'(frame_valid), 32'(0));
      checkOutput("resetErr", 32'(frame_err), 32'(0));
      checkOutput("resetBusy", 32'(busy), 32'(0));
      rx_in = 1'b1;
      rst   = 1'b0;
      holdBit(1'b1, 4);
      checkOutput("idleBusy", 32'(busy), 32'(0));

      $display("[TB] good frame 1010");
      applyStimulus(4'b1010, 1'b1, 1'b1);
      holdBit(1'b1, 4);

      $display("[TB] false start");
      holdBit(1'b0, 1);
      holdBit(1'b1, 3);
      checkOutput("falseStartBusy", 32'(busy), 32'(1));
      holdBit(1'b1, 3);
      checkOutput("falseStartIdle", 32'(busy), 32'(0));
      checkOutput("falseStartData", 32'(data_out), 32'(lastGoodData));
      checkOutput("falseStartPar", 32'(parity_out), 32'(lastGoodPar));

      $display("[TB] framing error with break");
      applyStimulus(4'b1010, 1'b1, 1'b1);
      applyStimulus(4'b0011, 1'b1, 1'b0);
      holdBit(1'b0, 36);
      checkOutput("breakBusy", 32'(busy), 32'(1));
      checkOutput("breakData", 32'(data_out), 32'(4'b1010));
      holdBit(1'b1, 4);
      checkOutput("breakRecovered", 32'(busy), 32'(0));
      applyStimulus(4'b0110, 1'b0, 1'b1);
      holdBit(1'b1, 4);

      $display("[TB] back-to-back frames");
      applyStimulus(4'b1111, 1'b1, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      holdBit(1'b1, 4);

      $display("[TB] reset mid-frame");
      holdBit(1'b0, CPB);
      holdBit(1'b1, CPB);
      holdBit(1'b0, CPB);
      holdBit(1'b1, 2);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      lastGoodData = '0;
      lastGoodPar  = 1'b0;
      checkOutput("midResetBusy", 32'(busy), 32'(0));
      checkOutput("midResetData", 32'(data_out), 32'(0));
      checkOutput("midResetValid", 32'(frame_valid), 32'(0));
      holdBit(1'b1, 4);
      applyStimulus(4'b0101, 1'b1, 1'b1);
      holdBit(1'b1, 4);

      $display("[TB] random frames");
      for (int n = 0; n < 30; n++) begin
         rd = DATA_W'($urandom);
         rp = 1'($urandom);
         rs = ($urandom_range(0, 4) != 0);
         applyStimulus(rd, rp, rs);
         if (!rs) begin
            holdBit(1'b0, $urandom_range(0, 10));
            holdBit(1'b1, $urandom_range(1, 5));
         end else begin
            holdBit(1'b1, $urandom_range(0, 6));
         end
      end
      holdBit(1'b1, 4);

      for (int w = 0; w < 200 && expQ.size() > 0; w++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("scoreboardDrained", 32'(expQ.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/odd_parity_frame_rx.md
Name: odd_parity_frame_rx

Overview:
Serial frame receiver that sits directly upstream of the odd-parity checker stage. It deserialises a UART-style frame from a single line: start bit, DATA_W data bits (LSB first), one odd-parity bit, one stop bit. It presents the captured data_out/parity_out pair with a one-cycle frame_valid strobe. Parity is not evaluated here; the downstream checker consumes data_out and parity_out.

Parameters:
DATA_W, 4, number of data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles per serial bit; even, >=2; H = CLKS_PER_BIT/2

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
rx_in  input  1  serial line; idles high; asynchronous to clk
data_out  output  DATA_W  last good frame's data bits; bit0 = first received
parity_out  output  1  last good frame's parity bit
frame_valid  output  1  one-cycle pulse: data_out/parity_out just updated
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; data_out=0; parity_out=0; frame_valid=0; frame_err=0; busy=0; synchroniser flops=1; counters=0. Reset overrides everything, including mid-frame; a partial frame is discarded with no pulse.
- Input sync: two-flop synchroniser gives rx_s, which is rx_in delayed 2 edges. The FSM uses only rx_s.
- Bit counter: $clog2(CLKS_PER_BIT) bits, cleared on every state entry and after every sample. It increments each cycle otherwise. The bit index counts data bits 0..DATA_W-1.
- States:
  - IDLE: rx_s=0 -> START.
  - START: sample when counter==H-1. Sample 0 -> DATA. Sample 1 is a false start -> IDLE, with no pulse.
  - DATA: sample when counter==CLKS_PER_BIT-1. Shift the sample into the shift register at position bit index (LSB first). After the DATA_W-th sample -> PARITY.
  - PARITY: sample at counter==CLKS_PER_BIT-1 into the parity register -> STOP.
  - STOP: sample at counter==CLKS_PER_BIT-1.
    - Sample 1: load data_out/parity_out from the shift/parity registers, assert frame_valid for the next cycle, -> IDLE.
    - Sample 0: assert frame_err for the next cycle; data_out/parity_out hold their previous values; -> WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then -> IDLE. No new frame is detected while the line is held low (break).
- Timing: let edge 0 be the first edge at which rx_in is low.
  - START is entered at edge 2.
  - The start sample is taken at edge 2+H.
  - Data bit i is sampled at edge 2+H+(i+1)*CLKS_PER_BIT.
  - The parity bit is sampled at edge 2+H+(DATA_W+1)*CLKS_PER_BIT.
  - The stop bit is sampled at edge S = 2+H+(DATA_W+2)*CLKS_PER_BIT.
  - frame_valid/frame_err are high from edge S to edge S+1.
  - Defaults: S = 28.
- Back-to-back frames: the return to IDLE at edge S lets a start bit that begins right after the stop bit be detected with no lost frame. The minimum frame spacing is (DATA_W+3)*CLKS_PER_BIT cycles.
- Outputs are registered. frame_valid and frame_err are never high in the same cycle. data_out/parity_out are stable between frame_valid pulses.
- busy=1 from START entry through the cycle the FSM returns to IDLE (includes WAIT_IDLE).

Test Plan:
1. Reset: rst=1 for 2 cycles with rx_in toggling -> all outputs 0, busy=0, no pulses.
2. Good frame, defaults: data 1010 (sent 0,1,0,1), parity 1, stop 1 -> frame_valid high exactly edge 28->29; data_out=4'b1010, parity_out=1, frame_err=0.
3. False start: rx_in low for 1 cycle, then high -> busy pulses briefly, START exits to IDLE; no frame_valid/frame_err; outputs unchanged.
4. Framing error: valid 1010/p=1 frame, then frame 0011/p=1 with stop=0 and line held low 40 cycles -> frame_err single pulse; data_out stays 1010; busy stays high until line returns high; the next good frame is received normally.
5. Back-to-back: 1111/p=1 then 0000/p=1 with zero idle gap -> two frame_valid pulses 28 cycles apart; data_out=1111 then 0000, parity_out=1 both times.
6. Reset mid-frame: assert rst during bit 2 of the DATA state -> state IDLE next cycle, busy=0, no pulse; the following full frame 0101/p=1 -> data_out=0101, parity_out=1.
